// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch port: one outstanding word request, completed by ack.
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, req/ack word fetch, one-entry stall buffer and
// branch/jump redirect with drain of an in-flight request.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_stage_if.master imem,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [31:0]   redirect_pc_i,
    output logic [31:0]   instr_o,
    output logic [31:0]   pc_plus4_o,
    output logic          instr_valid_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_BUFFER = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        req_q;
    logic [31:0] addr_q;
    logic [31:0] instr_q;
    logic [31:0] pc_plus4_q;
    logic        instr_valid_q;
    logic [31:0] buf_q;
    logic [31:0] buf_addr_q;

    logic        loadable_s;
    logic [31:0] target_s;
    logic [31:0] pc_inc_s;

    assign loadable_s = !instr_valid_q || !stall_i;
    assign target_s   = redirect_pc_i & 32'hFFFF_FFFC;
    assign pc_inc_s   = pc_q + 32'd4;

    assign imem.req      = req_q;
    assign imem.addr     = addr_q;
    assign instr_o       = instr_q;
    assign pc_plus4_o    = pc_plus4_q;
    assign instr_valid_o = instr_valid_q;

    // Fetch FSM with PC, output register and stall buffer all updated together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC & 32'hFFFF_FFFC;
            req_q         <= 1'b0;
            addr_q        <= 32'd0;
            instr_q       <= 32'd0;
            pc_plus4_q    <= 32'd0;
            instr_valid_q <= 1'b0;
            buf_q         <= 32'd0;
            buf_addr_q    <= 32'd0;
        end else begin
            // Consumption by decode; any load below overrides this.
            if (instr_valid_q && !stall_i) begin
                instr_valid_q <= 1'b0;
            end else begin
                instr_valid_q <= instr_valid_q;
            end

            if (redirect_i) begin
                instr_valid_q <= 1'b0;
                pc_q          <= target_s;
                case (state_q)
                    S_FETCH, S_DRAIN: begin
                        if (imem.ack) begin
                            state_q <= S_FETCH;
                            req_q   <= 1'b1;
                            addr_q  <= target_s;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end
                    S_IDLE, S_BUFFER: begin
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                        addr_q  <= target_s;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                    end
                endcase
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                    S_FETCH: begin
                        if (imem.ack && loadable_s) begin
                            instr_q       <= imem.rdata;
                            pc_plus4_q    <= addr_q + 32'd4;
                            instr_valid_q <= 1'b1;
                            pc_q          <= pc_inc_s;
                            addr_q        <= pc_inc_s;
                        end else if (imem.ack) begin
                            buf_q      <= imem.rdata;
                            buf_addr_q <= addr_q;
                            pc_q       <= pc_inc_s;
                            req_q      <= 1'b0;
                            state_q    <= S_BUFFER;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                    S_BUFFER: begin
                        if (!stall_i) begin
                            instr_q       <= buf_q;
                            pc_plus4_q    <= buf_addr_q + 32'd4;
                            instr_valid_q <= 1'b1;
                            state_q       <= S_FETCH;
                            req_q         <= 1'b1;
                            addr_q        <= pc_q;
                        end else begin
                            state_q <= S_BUFFER;
                        end
                    end
                    S_DRAIN: begin
                        // The acked word belongs to the abandoned path.
                        if (imem.ack) begin
                            state_q <= S_FETCH;
                            req_q   <= 1'b1;
                            addr_q  <= pc_q;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboard of delivered words checked as they
// appear on instr, plus a second instance exercising PC wrap and mid-run reset.
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;

    logic        rst2 = 1'b1;
    logic        stall2 = 1'b0;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'd0;
    logic [31:0] instr2;
    logic [31:0] pc42;
    logic        valid2;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb_q[$];

    fetch_stage_if m_if ();
    fetch_stage_if m_if2 ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rst_i(rst), .imem(m_if.master),
        .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .instr_o(instr), .pc_plus4_o(pc4), .instr_valid_o(valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk_i(clk), .rst_i(rst2), .imem(m_if2.master),
        .stall_i(stall2), .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
        .instr_o(instr2), .pc_plus4_o(pc42), .instr_valid_o(valid2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; any newly loaded instruction is popped and compared.
    task automatic step();
        logic ld;
        exp_t e;
        ld = !valid || !stall;
        @(posedge clk);
        #1;
        if (valid && ld) begin
            chk("sb_avail", {31'd0, (sb_q.size() > 0)}, 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("instr", instr, e.instr);
                chk("pc_plus4", pc4, e.pc4);
            end
        end
    endtask

    task automatic ack_word(input logic [31:0] data, input logic [31:0] exp_addr, input bit deliver);
        exp_t e;
        chk("ack_req", {31'd0, m_if.req}, 32'd1);
        chk("ack_addr", m_if.addr, exp_addr);
        m_if.ack   = 1'b1;
        m_if.rdata = data;
        if (deliver) begin
            e.instr = data;
            e.pc4   = exp_addr + 32'd4;
            sb_q.push_back(e);
        end
        step();
        m_if.ack   = 1'b0;
        m_if.rdata = 32'd0;
    endtask

    initial begin
        m_if.ack = 1'b0;   m_if.rdata = 32'd0;
        m_if2.ack = 1'b0;  m_if2.rdata = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, m_if.req}, 32'd0);
        chk("rst_addr", m_if.addr, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc4", pc4, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        rst = 1'b0;
        step();
        chk("first_req", {31'd0, m_if.req}, 32'd1);
        chk("first_addr", m_if.addr, 32'd0);
        chk("first_valid", {31'd0, valid}, 32'd0);

        // 1: streaming, one ack per cycle
        ack_word(32'h0022_1820, 32'd0, 1'b1);
        chk("s1_valid", {31'd0, valid}, 32'd1);
        ack_word(32'h1a04_0010, 32'd4, 1'b1);
        chk("s1_valid2", {31'd0, valid}, 32'd1);
        chk("s1_addr", m_if.addr, 32'd8);

        // 2: ack three cycles after the request
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s2_req", {31'd0, m_if.req}, 32'd1);
            chk("s2_addr", m_if.addr, 32'd8);
            chk("s2_valid", {31'd0, valid}, 32'd0);
        end
        ack_word(32'h8c43_0000, 32'd8, 1'b1);
        chk("s2_valid_after", {31'd0, valid}, 32'd1);

        // 3: ack under stall goes to the buffer
        stall = 1'b1;
        ack_word(32'h2088_a004, 32'd12, 1'b1);
        chk("s3_req", {31'd0, m_if.req}, 32'd0);
        chk("s3_instr_hold", instr, 32'h8c43_0000);
        chk("s3_valid_hold", {31'd0, valid}, 32'd1);
        step();
        chk("s3_req2", {31'd0, m_if.req}, 32'd0);
        chk("s3_instr_hold2", instr, 32'h8c43_0000);
        stall = 1'b0;
        step();
        chk("s3_resume_req", {31'd0, m_if.req}, 32'd1);
        chk("s3_resume_addr", m_if.addr, 32'd16);

        // 4: redirect with a request outstanding
        redirect = 1'b1;
        redirect_pc = 32'h0000_0043;
        step();
        redirect = 1'b0;
        chk("s4_valid", {31'd0, valid}, 32'd0);
        chk("s4_addr_hold", m_if.addr, 32'd16);
        chk("s4_req_hold", {31'd0, m_if.req}, 32'd1);
        step();
        chk("s4_addr_hold2", m_if.addr, 32'd16);
        chk("s4_valid2", {31'd0, valid}, 32'd0);
        ack_word(32'hdead_beef, 32'd16, 1'b0);
        chk("s4_target_addr", m_if.addr, 32'h0000_0040);
        chk("s4_valid3", {31'd0, valid}, 32'd0);
        ack_word(32'h0000_0020, 32'h0000_0040, 1'b1);

        // 5: redirect in the same cycle as an ack
        chk("s5_addr", m_if.addr, 32'h0000_0044);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0102;
        m_if.ack = 1'b1;
        m_if.rdata = 32'h0c00_1401;
        step();
        redirect = 1'b0;
        m_if.ack = 1'b0;
        m_if.rdata = 32'd0;
        chk("s5_valid", {31'd0, valid}, 32'd0);
        chk("s5_addr_target", m_if.addr, 32'h0000_0100);
        chk("s5_req", {31'd0, m_if.req}, 32'd1);
        ack_word(32'h3c01_1234, 32'h0000_0100, 1'b1);

        // 6: PC wrap and reset while buffered
        rst2 = 1'b0;
        step();
        chk("s6_addr0", m_if2.addr, 32'hFFFF_FFFC);
        chk("s6_req0", {31'd0, m_if2.req}, 32'd1);
        m_if2.ack = 1'b1;
        m_if2.rdata = 32'h1111_1111;
        step();
        m_if2.ack = 1'b0;
        chk("s6_instr", instr2, 32'h1111_1111);
        chk("s6_pc4_wrap", pc42, 32'd0);
        chk("s6_addr_wrap", m_if2.addr, 32'd0);
        chk("s6_valid", {31'd0, valid2}, 32'd1);
        stall2 = 1'b1;
        m_if2.ack = 1'b1;
        m_if2.rdata = 32'h2222_2222;
        step();
        m_if2.ack = 1'b0;
        chk("s6_buf_req", {31'd0, m_if2.req}, 32'd0);
        chk("s6_buf_instr", instr2, 32'h1111_1111);
        rst2 = 1'b1;
        m_if2.ack = 1'b1;
        m_if2.rdata = 32'hbad0_bad0;
        #2;
        chk("s6_rst_req", {31'd0, m_if2.req}, 32'd0);
        chk("s6_rst_addr", m_if2.addr, 32'd0);
        chk("s6_rst_instr", instr2, 32'd0);
        chk("s6_rst_pc4", pc42, 32'd0);
        chk("s6_rst_valid", {31'd0, valid2}, 32'd0);
        step();
        rst2 = 1'b0;
        stall2 = 1'b0;
        step();
        m_if2.ack = 1'b0;
        m_if2.rdata = 32'd0;
        chk("s6_restart_req", {31'd0, m_if2.req}, 32'd1);
        chk("s6_restart_addr", m_if2.addr, 32'hFFFF_FFFC);
        chk("s6_late_ack_valid", {31'd0, valid2}, 32'd0);
        chk("s6_late_ack_instr", instr2, 32'd0);

        step();
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
